streaming_fifo_mon: RTL
=======================

# streaming_fifo_mon

Parametrised AXI-Stream FIFO with first-word-fall-through output, programmable almost-full/almost-empty flags and a high-water-mark occupancy monitor. It sits between dataflow layers as the next-generation inter-layer buffer. It adds to the plain shift-register FIFO:
- BRAM-inferable storage for deep configurations;
- threshold flags for back-pressure-aware scheduling;
- a resettable peak-occupancy register, used to size FIFO depths from rtlsim runs.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4096, total capacity in words, including the output stage (>=2, any integer)
- AF_THRESH, 4080, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 16, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- CW (localparam), clog2(DEPTH+1), counter width; 13 for defaults

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst  in  1  reset; synchronous, active-high
- in0_V_TDATA  in  WIDTH  write data
- in0_V_TVALID  in  1  write valid
- in0_V_TREADY  out  1  FIFO can accept
- out_V_TDATA  out  WIDTH  read data; head of FIFO
- out_V_TVALID  out  1  head word present
- out_V_TREADY  in  1  consumer accepts
- count  out  CW  words currently held
- maxcount  out  CW  peak count since reset/clear
- clr_max  in  1  reload maxcount with the current count
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

## Operation
- Push = in0_V_TVALID & in0_V_TREADY at an edge. Pop = out_V_TVALID & out_V_TREADY at an edge.
- Data leaves in strict arrival order. No word is dropped, duplicated or reordered.
- count(next) = count + push - pop. It includes words in memory and in the output/prefetch stage. It never exceeds DEPTH.
- in0_V_TREADY is registered:
  - It is 1 iff the count after the current edge is < DEPTH.
  - It has no combinational path from out_V_TREADY.
  - A pop at full raises TREADY on the following cycle, giving a one-cycle write bubble at full. This is required and accepted.
- out_V_TVALID is registered and has no combinational path from in0_V_TVALID. Once asserted, TVALID stays high and TDATA stays stable until a pop.
- Storage:
  - Memory is a single-port-write/single-port-read array with 1-cycle registered read.
  - It feeds a 2-entry prefetch/output stage so that reads run at full throughput.
  - Read and write pointers wrap from DEPTH_MEM-1 to 0 (DEPTH_MEM = DEPTH-2) without a power-of-two assumption.
- maxcount is registered:
  - Each edge: if clr_max, maxcount <= count(next). Otherwise maxcount <= max(maxcount, count(next)).
  - clr_max has priority over the max update.
- almost_full and almost_empty are registered, computed from count(next), so they are coincident with count.
- Simultaneous push and pop: count is unchanged and both transfers complete. This includes the single-word case, where the word popped is the old head and the new word becomes the head.

## Timing
- Reset (ap_rst=1 at an edge):
  - After the edge: count=0, maxcount=0, out_V_TVALID=0, in0_V_TREADY=0, almost_full=0, almost_empty=1.
  - Pointers are cleared.
  - out_V_TDATA is don't-care while TVALID=0.
- First edge with ap_rst=0: in0_V_TREADY becomes 1. Reset asserted mid-stream discards all contents. Handshakes in the reset cycle are ignored.
- Fall-through latency: a push at edge k into an empty FIFO gives out_V_TVALID=1 and the pushed data after edge k (visible in cycle k+1).
- Throughput: with in0_V_TVALID=1 and out_V_TREADY=1 held, exactly 1 word/cycle flows in steady state. There are no bubbles unless the FIFO is full or empty.
- Back-pressure: with out_V_TREADY=0, the FIFO accepts DEPTH words back-to-back, then in0_V_TREADY=0 after the edge where count reaches DEPTH.
- Flags and count change only on edges, never mid-cycle.

## Test plan
- Reset then idle: after release, count=0, almost_empty=1, in0_V_TREADY=1 within 1 cycle, out_V_TVALID=0 → all hold indefinitely.
- Single word, DEPTH=4096, WIDTH=8: push 0xA5 at edge k with out_V_TREADY=0 → after edge k: out_V_TVALID=1, out_V_TDATA=0xA5, count=1, maxcount=1. Pop at k+1 → count=0, TVALID=0.
- Fill/drain, DEPTH=5 (non-power-of-two), AF=4, AE=1:
  - Push 0..9 with out_V_TREADY=0 → exactly 5 accepted; in0_V_TREADY=0 after count=5; almost_full=1 from count=4.
  - Then drain → 0,1,2,3,4 in order; almost_empty=1 at count<=1.
  - Repeat 3 times to exercise pointer wrap.
- Full-rate streaming: random valid/ready, 10k words, DEPTH=7 → scoreboard exact order. With both always high, 1 word/cycle after first latency. count equals the reference model every cycle.
- Simultaneous push/pop at count=1 and at count=DEPTH-1 → count unchanged, data order preserved. At full, a pop plus offered push gives no push that cycle and TREADY=1 next cycle.
- Monitor: fill to 37, drain to 3, assert clr_max → maxcount 37 then 3. Push 2 more → maxcount=5. Assert ap_rst with 20 words held → next cycle all outputs at reset values and no stale data emerges afterwards.

Source files
------------

// File: rtl/streaming_fifo_mon.sv
// rtl/streaming_fifo_mon.sv - AXI-Stream FWFT FIFO with threshold flags and peak-occupancy monitor
//
// Ports:
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   in0_V_TDATA/TVALID/TREADY      write stream (TREADY registered)
//   out_V_TDATA/TVALID/TREADY      read stream, head of FIFO (TVALID registered)
//   count                          words currently held (memory + output stage)
//   maxcount, clr_max              peak count since reset; clr_max reloads it with count
//   almost_full, almost_empty      registered threshold flags, coincident with count
module streaming_fifo_mon #(
    parameter int  WIDTH     = 8,
    parameter int  DEPTH     = 4096,
    parameter int  AF_THRESH = 4080,
    parameter int  AE_THRESH = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [WIDTH-1:0] in0_V_TDATA,
    input  logic             in0_V_TVALID,
    output logic             in0_V_TREADY,
    output logic [WIDTH-1:0] out_V_TDATA,
    output logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    maxcount,
    input  logic             clr_max,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int DEPTH_MEM = DEPTH - 2;
    localparam int MEM_N     = (DEPTH_MEM > 0) ? DEPTH_MEM : 1;
    localparam int AW        = (MEM_N > 1) ? $clog2(MEM_N) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
    localparam logic [AW-1:0] PTR_LAST = AW'(MEM_N - 1);

    logic [WIDTH-1:0] mem [MEM_N];
    logic [WIDTH-1:0] mem_q;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic [CW-1:0]    count_next;
    logic [1:0]       st_cnt;
    logic [1:0]       st_after_pop;
    logic             rd_pend;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             mem_wr;
    logic             mem_rd;

    assign out_V_TDATA = s0;

    // The output stage holds up to two words; an in-flight memory read reserves
    // one slot. Pushes skip the memory whenever it is empty and a slot is free,
    // which gives one-cycle fall-through and keeps the stage non-empty whenever
    // count is non-zero.
    always_comb begin
        push         = in0_V_TVALID & in0_V_TREADY;
        pop          = out_V_TVALID & out_V_TREADY;
        st_after_pop = st_cnt - {1'b0, pop};
        mem_rd       = (mem_cnt != '0) && ((st_after_pop + {1'b0, rd_pend}) < 2'd2);
        bypass       = push && (mem_cnt == '0) && ((st_after_pop + {1'b0, rd_pend}) < 2'd2);
        mem_wr       = push & ~bypass;
        count_next   = count + CW'(push) - CW'(pop);
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge ap_clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= in0_V_TDATA;
        end
        if (mem_rd) begin
            mem_q <= mem[rd_ptr];
        end
    end

    // Output stage data. An arriving memory word is always older than a
    // bypassed push, so it takes the lower slot when both land together.
    always_ff @(posedge ap_clk) begin
        if (pop) begin
            s0 <= s1;
        end
        if (rd_pend) begin
            if (st_after_pop == 2'd0) s0 <= mem_q;
            else                      s1 <= mem_q;
        end
        if (bypass) begin
            if ((st_after_pop + {1'b0, rd_pend}) == 2'd0) s0 <= in0_V_TDATA;
            else                                          s1 <= in0_V_TDATA;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            mem_cnt      <= '0;
            rd_pend      <= 1'b0;
            st_cnt       <= 2'd0;
            count        <= '0;
            maxcount     <= '0;
            in0_V_TREADY <= 1'b0;
            out_V_TVALID <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (mem_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            mem_cnt      <= mem_cnt + CW'(mem_wr) - CW'(mem_rd);
            rd_pend      <= mem_rd;
            st_cnt       <= st_after_pop + {1'b0, rd_pend} + {1'b0, bypass};
            count        <= count_next;
            out_V_TVALID <= (count_next != '0);
            in0_V_TREADY <= (count_next < DEPTH_C);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (clr_max || (count_next > maxcount)) begin
                maxcount <= count_next;
            end
        end
    end

endmodule
